// File: rtl/uart_rx.sv
// uart_rx: 8N1 oversampling UART receiver with valid/ready output, framing and overrun flags.
// Define UART_RX_PARITY_EN to receive an even-parity bit between the data and stop bits.
module uart_rx #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8
) (
    input  logic                 rst,
    input  logic                 clk_50m,
    input  logic                 rx_clk,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] C_V0  = CW'(OVERSAMPLE/2-1);
    localparam logic [CW-1:0] C_V1  = CW'(OVERSAMPLE/2);
    localparam logic [CW-1:0] C_DEC = CW'(OVERSAMPLE/2+1);
    localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE-1);
    localparam logic [BW-1:0] B_END = BW'(DATA_BITS-1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t               state_q, state_d;
    logic                 rxd_m_q, rxd_s_q, rxc_m_q, rxc_s_q, rxc_p_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        idx_q, idx_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] sh_q, sh_d, rx_data_q;
    logic                 par_bad_q, par_bad_d;
    logic                 rx_valid_q, frame_err_q, overrun_q, parity_err_q;
    logic                 deliver, ferr_d, perr_d, tick, vote, dec;

    assign tick = rxc_s_q & ~rxc_p_q;
    assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s_q) | (smp_q[1] & rxd_s_q);
    assign dec  = cnt_q == C_DEC;

    always_ff @(posedge clk_50m or posedge rst)
        if (rst) begin
            {rxd_m_q, rxd_s_q} <= 2'b11;
            {rxc_m_q, rxc_s_q, rxc_p_q} <= 3'b000;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            smp_q     <= 2'b11;
            sh_q      <= '0;
            par_bad_q <= 1'b0;
        end else begin
            {rxd_m_q, rxd_s_q} <= {rxd, rxd_m_q};
            {rxc_m_q, rxc_s_q, rxc_p_q} <= {rx_clk, rxc_m_q, rxc_s_q};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            smp_q     <= smp_d;
            sh_q      <= sh_d;
            par_bad_q <= par_bad_d;
        end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        smp_d     = smp_q;
        sh_d      = sh_q;
        par_bad_d = par_bad_q;
        deliver   = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        if (tick) begin
            cnt_d    = cnt_q == C_END ? '0 : cnt_q + 1'b1;
            smp_d[0] = cnt_q == C_V0 ? rxd_s_q : smp_q[0];
            smp_d[1] = cnt_q == C_V1 ? rxd_s_q : smp_q[1];
            case (state_q)
                IDLE: if (!rxd_s_q) begin
                    state_d   = START;
                    cnt_d     = CW'(1);
                    par_bad_d = 1'b0;
                end
                START: if (dec && vote) state_d = IDLE;
                    else if (cnt_q == C_END) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                DATA: begin
                    if (dec) sh_d = {vote, sh_q[DATA_BITS-1:1]};
                    if (cnt_q == C_END) begin
                        idx_d = idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (idx_q == B_END) state_d = PARITY;
`else
                        if (idx_q == B_END) state_d = STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (dec && vote != ^sh_q) begin
                        perr_d    = 1'b1;
                        par_bad_d = 1'b1;
                    end
                    if (cnt_q == C_END) state_d = STOP;
                end
`endif
                // Leave mid-stop-bit so an immediately following start edge is not missed
                STOP: if (dec) begin
                    state_d = vote ? IDLE : BREAK;
                    deliver = vote & ~par_bad_q;
                    ferr_d  = ~vote;
                end
                BREAK: if (rxd_s_q) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50m or posedge rst)
        if (rst) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            frame_err_q  <= ferr_d;
            parity_err_q <= perr_d;
            if (deliver && (!rx_valid_q || rx_ready)) begin
                rx_data_q  <= sh_q;
                rx_valid_q <= 1'b1;
            end else begin
                if (deliver) overrun_q <= 1'b1;
                if (rx_ready) rx_valid_q <= 1'b0;
            end
        end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign parity_err = parity_err_q;
endmodule
